// File: rtl/cve2_obi_arbiter.sv
// cve2_obi_arbiter
//   Shares one OBI-style memory port between the cve2 instruction-fetch and
//   LSU (data) interfaces. A request that is offered but not granted is locked
//   until it is granted. The source of every granted transaction is queued in
//   an in-order ID FIFO, so each bus response is routed back to its requester.
//
// Ports
//   clk_i, rst_i                     clock, asynchronous active-high reset
//   instr_req_i/addr_i               fetch request and address
//   instr_gnt_o/rvalid_o/rdata_o/err_o   fetch grant and response
//   data_req_i/we_i/be_i/addr_i/wdata_i  LSU request and payload
//   data_gnt_o/rvalid_o/rdata_o/err_o    LSU grant and response
//   bus_req_o/we_o/be_o/addr_o/wdata_o   shared-port request and payload
//   bus_gnt_i/rvalid_i/rdata_i/err_i     shared-port grant and response
//   busy_o       transaction outstanding or request locked
//   spurious_o   sticky: a response arrived with nothing outstanding
//   lock_state_o debug view of the lock FSM (0 idle, 1 fetch locked, 2 LSU locked)
//
// Handshake: a transfer happens on every rising edge where req=1 and gnt=1.
// A requester keeps req and payload stable until gnt. A response is one cycle
// with rvalid=1; rdata/err are only meaningful while rvalid=1.
//
// Configuration
//   CVE2_OBI_ARB_RR_EN  defined: round-robin between the sources when unlocked
//                       (data preferred after reset). Undefined: data always
//                       has priority over fetch.
module cve2_obi_arbiter #(
  parameter int MAX_OUTSTANDING = 2,
  parameter int ADDR_W          = 32,
  parameter int DATA_W          = 32
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                instr_req_i,
  input  logic [ADDR_W-1:0]   instr_addr_i,
  output logic                instr_gnt_o,
  output logic                instr_rvalid_o,
  output logic [DATA_W-1:0]   instr_rdata_o,
  output logic                instr_err_o,
  input  logic                data_req_i,
  input  logic                data_we_i,
  input  logic [DATA_W/8-1:0] data_be_i,
  input  logic [ADDR_W-1:0]   data_addr_i,
  input  logic [DATA_W-1:0]   data_wdata_i,
  output logic                data_gnt_o,
  output logic                data_rvalid_o,
  output logic [DATA_W-1:0]   data_rdata_o,
  output logic                data_err_o,
  output logic                bus_req_o,
  output logic                bus_we_o,
  output logic [DATA_W/8-1:0] bus_be_o,
  output logic [ADDR_W-1:0]   bus_addr_o,
  output logic [DATA_W-1:0]   bus_wdata_o,
  input  logic                bus_gnt_i,
  input  logic                bus_rvalid_i,
  input  logic [DATA_W-1:0]   bus_rdata_i,
  input  logic                bus_err_i,
  output logic                busy_o,
  output logic                spurious_o,
  output logic [1:0]          lock_state_o
);

  localparam int   CW    = $clog2(MAX_OUTSTANDING + 1);
  localparam int   PW    = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam logic SRC_I = 1'b0;
  localparam logic SRC_D = 1'b1;

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_LOCK_I = 2'd1, ST_LOCK_D = 2'd2} lock_state_e;

  lock_state_e   state_q, state_d;
  logic          locked, lock_sel;
  logic          sel, sel_req, grant, pop, head;
  logic          fifo_full, fifo_empty;
  logic          id_q [MAX_OUTSTANDING];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          spurious_q;
`ifdef CVE2_OBI_ARB_RR_EN
  logic          last_q;
`endif

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
  endfunction

  // Lock FSM: state register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Lock FSM: next state. While full, bus_req_o is 0 so the lock is retained.
  always_comb begin
    state_d = state_q;
    if (grant)                       state_d = ST_IDLE;
    else if (bus_req_o && !bus_gnt_i) state_d = (sel == SRC_D) ? ST_LOCK_D : ST_LOCK_I;
  end

  // Lock FSM: outputs
  always_comb begin
    locked       = (state_q != ST_IDLE);
    lock_sel     = (state_q == ST_LOCK_D);
    lock_state_o = state_q;
  end

  // Source selection: a locked request wins, otherwise priority decides.
  always_comb begin
    sel = lock_sel;
    if (!locked) begin
`ifdef CVE2_OBI_ARB_RR_EN
      if (data_req_i && instr_req_i) sel = (last_q == SRC_D) ? SRC_I : SRC_D;
      else                           sel = data_req_i ? SRC_D : SRC_I;
`else
      sel = data_req_i ? SRC_D : SRC_I;
`endif
    end
  end

  assign fifo_full  = (count_q == CW'(MAX_OUTSTANDING));
  assign fifo_empty = (count_q == '0);
  assign sel_req    = (sel == SRC_D) ? data_req_i : instr_req_i;
  assign bus_req_o  = sel_req & ~fifo_full;
  assign grant      = bus_req_o & bus_gnt_i;
  assign pop        = bus_rvalid_i & ~fifo_empty;
  assign head       = id_q[rd_ptr_q];

  always_comb begin
    bus_we_o    = 1'b0;
    bus_be_o    = '1;
    bus_addr_o  = instr_addr_i;
    bus_wdata_o = '0;
    if (sel == SRC_D) begin
      bus_we_o    = data_we_i;
      bus_be_o    = data_be_i;
      bus_addr_o  = data_addr_i;
      bus_wdata_o = data_wdata_i;
    end
  end

  assign instr_gnt_o    = grant & (sel == SRC_I);
  assign data_gnt_o     = grant & (sel == SRC_D);
  assign instr_rvalid_o = pop & (head == SRC_I);
  assign data_rvalid_o  = pop & (head == SRC_D);
  assign instr_rdata_o  = bus_rdata_i;
  assign data_rdata_o   = bus_rdata_i;
  assign instr_err_o    = bus_err_i & instr_rvalid_o;
  assign data_err_o     = bus_err_i & data_rvalid_o;
  assign busy_o         = ~fifo_empty | locked;
  assign spurious_o     = spurious_q;

  // Source-ID FIFO. Push and pop together leave the count unchanged.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < MAX_OUTSTANDING; i++) id_q[i] <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      spurious_q <= 1'b0;
    end else begin
      if (grant) begin
        id_q[wr_ptr_q] <= sel;
        wr_ptr_q       <= ptr_inc(wr_ptr_q);
      end
      if (pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
      if (grant && !pop)      count_q <= count_q + 1'b1;
      else if (!grant && pop) count_q <= count_q - 1'b1;
      if (bus_rvalid_i && fifo_empty) spurious_q <= 1'b1;
    end
  end

`ifdef CVE2_OBI_ARB_RR_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)      last_q <= SRC_I;
    else if (grant) last_q <= sel;
  end
`endif

  // Count can neither overflow nor underflow.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      assert (!(grant && !pop && fifo_full));
      assert (!(pop && fifo_empty));
    end
  end

endmodule

// File: tb/tb_cve2_obi_arbiter.sv
module tb_cve2_obi_arbiter;

`ifdef CVE2_OBI_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif
  localparam int MAXO = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        instr_req = 0, data_req = 0, data_we = 0;
  logic [31:0] instr_addr = 0, data_addr = 0, data_wdata = 0;
  logic [3:0]  data_be = 0;
  logic        bus_gnt = 0, bus_rvalid = 0, bus_err = 0;
  logic [31:0] bus_rdata = 0;

  logic        instr_gnt_o, instr_rvalid_o, instr_err_o;
  logic [31:0] instr_rdata_o;
  logic        data_gnt_o, data_rvalid_o, data_err_o;
  logic [31:0] data_rdata_o;
  logic        bus_req_o, bus_we_o;
  logic [3:0]  bus_be_o;
  logic [31:0] bus_addr_o, bus_wdata_o;
  logic        busy_o, spurious_o;
  logic [1:0]  lock_state_o;

  int checks = 0;
  int errors = 0;

  cve2_obi_arbiter #(.MAX_OUTSTANDING(MAXO), .ADDR_W(32), .DATA_W(32)) dut (
    .clk_i(clk), .rst_i(rst),
    .instr_req_i(instr_req), .instr_addr_i(instr_addr),
    .instr_gnt_o(instr_gnt_o), .instr_rvalid_o(instr_rvalid_o),
    .instr_rdata_o(instr_rdata_o), .instr_err_o(instr_err_o),
    .data_req_i(data_req), .data_we_i(data_we), .data_be_i(data_be),
    .data_addr_i(data_addr), .data_wdata_i(data_wdata),
    .data_gnt_o(data_gnt_o), .data_rvalid_o(data_rvalid_o),
    .data_rdata_o(data_rdata_o), .data_err_o(data_err_o),
    .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_be_o(bus_be_o),
    .bus_addr_o(bus_addr_o), .bus_wdata_o(bus_wdata_o),
    .bus_gnt_i(bus_gnt), .bus_rvalid_i(bus_rvalid), .bus_rdata_i(bus_rdata),
    .bus_err_i(bus_err), .busy_o(busy_o), .spurious_o(spurious_o),
    .lock_state_o(lock_state_o)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model + compare process ----------------
  // exp_q holds the source (1 = data, 0 = fetch) of each granted, unanswered transfer.
  logic [0:0] exp_q[$];
  bit  m_lock, m_lsel, m_last, m_spur;
  bit  e_sel, e_req, e_ig, e_dg, e_irv, e_drv, e_pop;

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      m_lock = 0; m_lsel = 0; m_last = 0; m_spur = 0;
    end else begin
      if (m_lock)                         e_sel = m_lsel;
      else if (RR && data_req && instr_req) e_sel = !m_last;
      else                                e_sel = data_req;
      e_req = (e_sel ? data_req : instr_req) && (exp_q.size() < MAXO);
      e_ig  = e_req && bus_gnt && !e_sel;
      e_dg  = e_req && bus_gnt && e_sel;
      e_pop = bus_rvalid && exp_q.size() > 0;
      e_irv = e_pop && exp_q[0] == 1'b0;
      e_drv = e_pop && exp_q[0] == 1'b1;
      check("bus_req", bus_req_o, e_req);
      if (e_req) begin
        check("bus_addr",  bus_addr_o,  e_sel ? data_addr : instr_addr);
        check("bus_we",    bus_we_o,    e_sel ? data_we : 1'b0);
        check("bus_be",    bus_be_o,    e_sel ? data_be : 4'hF);
        check("bus_wdata", bus_wdata_o, e_sel ? data_wdata : 32'h0);
      end
      check("instr_gnt", instr_gnt_o, e_ig);
      check("data_gnt",  data_gnt_o,  e_dg);
      check("instr_rvalid", instr_rvalid_o, e_irv);
      check("data_rvalid",  data_rvalid_o,  e_drv);
      if (e_irv) begin
        check("instr_rdata", instr_rdata_o, bus_rdata);
        check("instr_err",   instr_err_o,   bus_err);
      end
      if (e_drv) begin
        check("data_rdata", data_rdata_o, bus_rdata);
        check("data_err",   data_err_o,   bus_err);
      end
      check("busy",     busy_o,     (exp_q.size() != 0) || m_lock);
      check("spurious", spurious_o, m_spur);
      // advance the model to the next cycle
      if (e_pop) void'(exp_q.pop_front());
      if (bus_rvalid && !e_pop) m_spur = 1;
      if (e_req && bus_gnt) begin
        exp_q.push_back(e_sel);
        m_lock = 0;
        m_last = e_sel;
      end else if (e_req) begin
        m_lock = 1;
        m_lsel = e_sel;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic clear_inputs();
    instr_req = 0; data_req = 0; data_we = 0; data_be = 0;
    instr_addr = 0; data_addr = 0; data_wdata = 0;
    bus_gnt = 0; bus_rvalid = 0; bus_err = 0; bus_rdata = 0;
  endtask

  task automatic do_reset();
    rst = 1;
    clear_inputs();
    repeat (2) @(posedge clk);
    #1 rst = 0;
  endtask

  int pend;
  bit ig, dg;
  logic [3:0] gseq;
  logic [3:0] gseq_exp;

  initial begin
    clear_inputs();
    do_reset();

    // reset state
    @(negedge clk);
    check("rst_busy", busy_o, 0);
    check("rst_spurious", spurious_o, 0);
    check("rst_bus_req", bus_req_o, 0);
    check("rst_rvalids", {instr_rvalid_o, data_rvalid_o, instr_gnt_o, data_gnt_o}, 0);

    // response with nothing outstanding: flagged, not forwarded
    tick(); bus_rvalid = 1; bus_err = 1; bus_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    check("spur_no_rvalid", {instr_rvalid_o, data_rvalid_o, instr_err_o, data_err_o}, 0);
    tick(); bus_rvalid = 0; bus_err = 0;
    @(negedge clk); check("spur_set", spurious_o, 1);
    tick(); tick();
    @(negedge clk); check("spur_sticky", spurious_o, 1);
    do_reset();

    // single fetch, response two cycles after grant
    instr_req = 1; instr_addr = 32'h3000_0000; bus_gnt = 1;
    @(negedge clk);
    check("t1_gnt", instr_gnt_o, 1);
    check("t1_addr", bus_addr_o, 32'h3000_0000);
    check("t1_be", bus_be_o, 4'hF);
    tick(); instr_req = 0; bus_gnt = 0;
    @(negedge clk); check("t1_busy", busy_o, 1);
    tick(); bus_rvalid = 1; bus_rdata = 32'h0000_0013;
    @(negedge clk);
    check("t1_rvalid", instr_rvalid_o, 1);
    check("t1_rdata", instr_rdata_o, 32'h0000_0013);
    check("t1_data_rvalid", data_rvalid_o, 0);
    tick(); bus_rvalid = 0;
    @(negedge clk); check("t1_idle", busy_o, 0);
    do_reset();

    // both request together: data first, then fetch; responses in order
    instr_req = 1; instr_addr = 32'h100; data_req = 1; data_addr = 32'h200; bus_gnt = 1;
    @(negedge clk); check("t2_first_data", {data_gnt_o, instr_gnt_o}, 2'b10);
    tick(); data_req = 0;
    @(negedge clk); check("t2_second_instr", {data_gnt_o, instr_gnt_o}, 2'b01);
    tick(); instr_req = 0; bus_gnt = 0; bus_rvalid = 1; bus_rdata = 32'h11;
    @(negedge clk); check("t2_rsp_data", {data_rvalid_o, instr_rvalid_o}, 2'b10);
    tick(); bus_rdata = 32'h22; bus_err = 1;
    @(negedge clk);
    check("t2_rsp_instr", {data_rvalid_o, instr_rvalid_o}, 2'b01);
    check("t2_instr_err", instr_err_o, 1);
    tick(); bus_rvalid = 0; bus_err = 0;
    do_reset();

    // lock: data held without grant, fetch arrives, no switch
    data_req = 1; data_addr = 32'hA000_0040; data_we = 1; data_be = 4'h3; data_wdata = 32'h55;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t3_lock_addr", bus_addr_o, 32'hA000_0040);
      check("t3_no_igrant", instr_gnt_o, 0);
      tick();
      if (i == 1) begin instr_req = 1; instr_addr = 32'h44; end
    end
    bus_gnt = 1;
    @(negedge clk); check("t3_data_gnt", data_gnt_o, 1);
    tick(); data_req = 0;
    @(negedge clk); check("t3_instr_next", instr_gnt_o, 1);
    tick(); instr_req = 0; bus_gnt = 0;
    do_reset();

    // fill the FIFO, then free it
    data_req = 1; data_addr = 32'h8; bus_gnt = 1;
    tick(); tick();
    @(negedge clk);
    check("t4_full_req", bus_req_o, 0);
    check("t4_full_gnt", data_gnt_o, 0);
    tick(); bus_rvalid = 1;
    @(negedge clk);
    check("t4_full_pop", data_rvalid_o, 1);
    check("t4_still_full", bus_req_o, 0);
    tick(); bus_rvalid = 1;
    @(negedge clk); check("t4_after_pop", bus_req_o, 1);
    tick(); bus_rvalid = 0;
    @(negedge clk); check("t4_pushpop_kept", bus_req_o, 1);
    tick();
    @(negedge clk); check("t4_full_again", bus_req_o, 0);
    do_reset();

    // both held, grant every cycle: grant order depends on the build
    data_req = 1; instr_req = 1; bus_gnt = 1; gseq = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      gseq[i] = data_gnt_o;
      tick(); bus_rvalid = 1;
    end
    gseq_exp = RR ? 4'b0101 : 4'b1111;
    check("t6_grant_order", gseq, gseq_exp);
    data_req = 0; instr_req = 0; bus_gnt = 0; bus_rvalid = 0;
    do_reset();

    // randomized traffic; requesters hold req until granted
    pend = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      ig = instr_gnt_o; dg = data_gnt_o;
      if (bus_rvalid && pend > 0) pend--;
      if (bus_req_o && bus_gnt) pend++;
      tick();
      if (!instr_req || ig) begin
        instr_req  = ($urandom_range(0, 1) == 1);
        instr_addr = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
      end
      if (!data_req || dg) begin
        data_req   = ($urandom_range(0, 2) != 0);
        data_addr  = $urandom;
        data_we    = $urandom_range(0, 1);
        data_be    = 4'($urandom_range(0, 15));
        data_wdata = $urandom;
      end
      bus_gnt    = ($urandom_range(0, 3) != 0);
      bus_rvalid = (pend > 0) && ($urandom_range(0, 1) == 1);
      bus_rdata  = $urandom;
      bus_err    = ($urandom_range(0, 7) == 0);
    end

    // reset mid-traffic: late responses are spurious
    data_req = 1; bus_gnt = 1; bus_rvalid = 0;
    tick();
    do_reset();
    bus_rvalid = 1; bus_rdata = 32'h77;
    @(negedge clk);
    check("mid_rst_no_rvalid", {instr_rvalid_o, data_rvalid_o}, 0);
    tick(); bus_rvalid = 0;
    @(negedge clk); check("mid_rst_spurious", spurious_o, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
